// File: rtl/forward_sel_unit_if.sv
// ID-stage instruction fields into the forwarding unit, registered mux selects and stall out.
// Latency: none, this is a bundle of wires; the master drives the ID fields and the unit drives the results.
interface forward_sel_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              Flush;
  logic              IdValid;
  logic [REG_AW-1:0] IdRn;
  logic [REG_AW-1:0] IdRm;
  logic              IdUseRn;
  logic              IdUseRm;
  logic [REG_AW-1:0] IdRd;
  logic              IdRegWrite;
  logic              IdMemRead;
  logic [1:0]        SelA;
  logic [1:0]        SelB;
  logic              Stall;
  logic [CNT_W-1:0]  StallCount;

  modport master (
    output Flush, IdValid, IdRn, IdRm, IdUseRn, IdUseRm, IdRd, IdRegWrite, IdMemRead,
    input  SelA, SelB, Stall, StallCount
  );

  modport slave (
    input  Flush, IdValid, IdRn, IdRm, IdUseRn, IdUseRm, IdRd, IdRegWrite, IdMemRead,
    output SelA, SelB, Stall, StallCount
  );
endinterface

// File: rtl/forward_sel_unit.sv
// Forwarding-select codes for the EX operand muxes plus load-use stall, tracking EX/MEM destinations.
// Latency: SelA/SelB registered, 1 cycle after ID inputs; Stall is combinational (0 cycles).
// Backpressure: Stall holds PC and IF/ID and injects a bubble into EX; Flush overrides Stall.
module forward_sel_unit #(
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16
) (
  input logic               Clk,
  input logic               Rst,
  forward_sel_unit_if.slave bus
);
  localparam logic [REG_AW-1:0] ZR       = REG_AW'(ZERO_REG);
  localparam logic [1:0]        SEL_RF   = 2'd0;
  localparam logic [1:0]        SEL_EX   = 2'd1;
  localparam logic [1:0]        SEL_MEM  = 2'd2;
  localparam logic [1:0]        SEL_ZERO = 2'd3;

  logic              ex_v_q,   ex_v_d;
  logic              ex_rw_q,  ex_rw_d;
  logic              ex_ld_q,  ex_ld_d;
  logic [REG_AW-1:0] ex_rd_q,  ex_rd_d;
  logic              mem_v_q,  mem_v_d;
  logic              mem_rw_q, mem_rw_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic [1:0]        sel_a_q,  sel_a_d;
  logic [1:0]        sel_b_q,  sel_b_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;

  logic ex_prod;
  logic mem_prod;
  logic rn_hit_ex;
  logic rm_hit_ex;
  logic stall;
  logic advance;

  // The EX slot is checked first so the youngest producer wins when both slots match.
  function automatic logic [1:0] sel_code(
    input logic              use_src,
    input logic [REG_AW-1:0] src,
    input logic              ex_p,
    input logic [REG_AW-1:0] ex_rd,
    input logic              mem_p,
    input logic [REG_AW-1:0] mem_rd
  );
    if (!use_src) begin
      return SEL_RF;
    end
    if (src == ZR) begin
      return SEL_ZERO;
    end
    if (ex_p && (src == ex_rd)) begin
      return SEL_EX;
    end
    if (mem_p && (src == mem_rd)) begin
      return SEL_MEM;
    end
    return SEL_RF;
  endfunction

  always_comb begin
    ex_prod   = ex_v_q & ex_rw_q & (ex_rd_q != ZR);
    mem_prod  = mem_v_q & mem_rw_q & (mem_rd_q != ZR);
    rn_hit_ex = bus.IdUseRn & (bus.IdRn == ex_rd_q);
    rm_hit_ex = bus.IdUseRm & (bus.IdRm == ex_rd_q);
    stall     = bus.IdValid & ~bus.Flush & ex_ld_q & ex_prod & (rn_hit_ex | rm_hit_ex);
    advance   = bus.IdValid & ~stall & ~bus.Flush;
  end

  // MEM always takes the old EX slot, even on a flush; only EX and ID are killed.
  always_comb begin
    mem_v_d  = ex_v_q;
    mem_rw_d = ex_rw_q;
    mem_rd_d = ex_rd_q;
    ex_v_d   = 1'b0;
    ex_rw_d  = 1'b0;
    ex_ld_d  = 1'b0;
    ex_rd_d  = '0;
    sel_a_d  = SEL_RF;
    sel_b_d  = SEL_RF;
    cnt_d    = cnt_q;
    if (advance) begin
      ex_v_d  = 1'b1;
      ex_rw_d = bus.IdRegWrite;
      ex_ld_d = bus.IdMemRead;
      ex_rd_d = bus.IdRd;
      sel_a_d = sel_code(bus.IdUseRn, bus.IdRn, ex_prod, ex_rd_q, mem_prod, mem_rd_q);
      sel_b_d = sel_code(bus.IdUseRm, bus.IdRm, ex_prod, ex_rd_q, mem_prod, mem_rd_q);
    end
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ex_v_q   <= 1'b0;
      ex_rw_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      ex_rd_q  <= '0;
      mem_v_q  <= 1'b0;
      mem_rw_q <= 1'b0;
      mem_rd_q <= '0;
      sel_a_q  <= SEL_RF;
      sel_b_q  <= SEL_RF;
      cnt_q    <= '0;
    end else begin
      ex_v_q   <= ex_v_d;
      ex_rw_q  <= ex_rw_d;
      ex_ld_q  <= ex_ld_d;
      ex_rd_q  <= ex_rd_d;
      mem_v_q  <= mem_v_d;
      mem_rw_q <= mem_rw_d;
      mem_rd_q <= mem_rd_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.SelA       = sel_a_q;
  assign bus.SelB       = sel_b_q;
  assign bus.Stall      = stall;
  assign bus.StallCount = cnt_q;
endmodule

// File: tb/tb_forward_sel_unit.sv
// Directed bench for forward_sel_unit: a pipeline-history model checked every cycle plus literal checks.
// A second instance with a 4-bit counter shares the stimulus so saturation is reached quickly.
module tb_forward_sel_unit;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   cmp_en = 1'b0;

  forward_sel_unit_if #(.REG_AW(5), .CNT_W(16)) mif ();
  forward_sel_unit_if #(.REG_AW(5), .CNT_W(4))  sif ();

  forward_sel_unit #(.REG_AW(5), .ZERO_REG(31), .CNT_W(16)) u_dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (mif.slave)
  );

  forward_sel_unit #(.REG_AW(5), .ZERO_REG(31), .CNT_W(4)) u_sat (
    .Clk (Clk),
    .Rst (Rst),
    .bus (sif.slave)
  );

  assign sif.Flush      = mif.Flush;
  assign sif.IdValid    = mif.IdValid;
  assign sif.IdRn       = mif.IdRn;
  assign sif.IdRm       = mif.IdRm;
  assign sif.IdUseRn    = mif.IdUseRn;
  assign sif.IdUseRm    = mif.IdUseRm;
  assign sif.IdRd       = mif.IdRd;
  assign sif.IdRegWrite = mif.IdRegWrite;
  assign sif.IdMemRead  = mif.IdMemRead;

  always #5 Clk = ~Clk;

  // Model: hist[age] is the instruction issued age+1 cycles before the one now in ID (bubble = v 0).
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } ent_t;

  ent_t       hist [2];
  logic [1:0] e_sel_a;
  logic [1:0] e_sel_b;
  logic [15:0] e_cnt;
  logic [3:0]  e_cnt_s;

  function automatic bit writes_reg(input ent_t e);
    return e.v && e.wr && (e.rd != 5'd31);
  endfunction

  function automatic bit m_stall();
    if (!Rst || !mif.IdValid || mif.Flush) return 1'b0;
    if (!(writes_reg(hist[0]) && hist[0].ld)) return 1'b0;
    return (mif.IdUseRn && (mif.IdRn == hist[0].rd)) || (mif.IdUseRm && (mif.IdRm == hist[0].rd));
  endfunction

  function automatic bit m_adv();
    return mif.IdValid && !mif.Flush && !m_stall();
  endfunction

  function automatic logic [1:0] m_sel(input bit used, input logic [4:0] src);
    if (!used) return 2'd0;
    if (src == 5'd31) return 2'd3;
    for (int age = 0; age < 2; age++) begin
      if (writes_reg(hist[age]) && (hist[age].rd == src)) return 2'(age + 1);
    end
    return 2'd0;
  endfunction

  function automatic ent_t id_ent();
    ent_t e;
    e.v  = 1'b1;
    e.rd = mif.IdRd;
    e.wr = mif.IdRegWrite;
    e.ld = mif.IdMemRead;
    return e;
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      hist[0] <= '0;
      hist[1] <= '0;
      e_sel_a <= 2'd0;
      e_sel_b <= 2'd0;
      e_cnt   <= 16'd0;
      e_cnt_s <= 4'd0;
    end else begin
      hist[1] <= hist[0];
      hist[0] <= m_adv() ? id_ent() : ent_t'(0);
      e_sel_a <= m_adv() ? m_sel(mif.IdUseRn, mif.IdRn) : 2'd0;
      e_sel_b <= m_adv() ? m_sel(mif.IdUseRm, mif.IdRm) : 2'd0;
      e_cnt   <= (m_stall() && (e_cnt != 16'hFFFF)) ? e_cnt + 16'd1 : e_cnt;
      e_cnt_s <= (m_stall() && (e_cnt_s != 4'hF)) ? e_cnt_s + 4'd1 : e_cnt_s;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("model_stall", 32'(mif.Stall), 32'(m_stall()));
      chk("model_sel_a", 32'(mif.SelA), 32'(e_sel_a));
      chk("model_sel_b", 32'(mif.SelB), 32'(e_sel_b));
      chk("model_count", 32'(mif.StallCount), 32'(e_cnt));
      chk("model_sat_stall", 32'(sif.Stall), 32'(m_stall()));
      chk("model_sat_count", 32'(sif.StallCount), 32'(e_cnt_s));
    end
  end

  task automatic put(input bit v, input int rd, input int rn, input int rm,
                     input bit urn, input bit urm, input bit rw, input bit ld, input bit fl);
    mif.IdValid    = v;
    mif.IdRd       = 5'(rd);
    mif.IdRn       = 5'(rn);
    mif.IdRm       = 5'(rm);
    mif.IdUseRn    = urn;
    mif.IdUseRm    = urm;
    mif.IdRegWrite = rw;
    mif.IdMemRead  = ld;
    mif.Flush      = fl;
  endtask

  task automatic nop();
    put(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add(input int rd, input int rn, input int rm);
    put(1'b1, rd, rn, rm, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic ldur(input int rd, input int rn);
    put(1'b1, rd, rn, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    nop();
    tick();
    tick();
  endtask

  task automatic chk_sel(input string name, input logic [1:0] a, input logic [1:0] b);
    chk({name, "_a"}, 32'(mif.SelA), 32'(a));
    chk({name, "_b"}, 32'(mif.SelB), 32'(b));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    nop();
    Rst = 1'b0;
    #12;
    chk_sel("reset_sel", 2'd0, 2'd0);
    chk("reset_stall", 32'(mif.Stall), 32'd0);
    chk("reset_count", 32'(mif.StallCount), 32'd0);
    cmp_en = 1'b1;
    Rst = 1'b1;
    tick();

    // Back-to-back dependency forwards from EX/MEM.
    add(1, 5, 6);  tick(); chk_sel("first_add", 2'd0, 2'd0);
    add(2, 1, 1);  tick(); chk_sel("fwd_ex", 2'd1, 2'd1);
    drain();

    // One unrelated instruction between: forward from MEM/WB.
    add(1, 5, 6);  tick();
    add(7, 8, 9);  tick();
    add(2, 1, 1);  tick(); chk_sel("fwd_mem", 2'd2, 2'd2);
    drain();

    // Two between: value already in the regfile.
    add(1, 5, 6);  tick();
    add(7, 8, 9);  tick();
    add(10, 11, 12); tick();
    add(2, 1, 1);  tick(); chk_sel("fwd_none", 2'd0, 2'd0);
    drain();

    // Load-use: one stall cycle, then forward from MEM/WB.
    ldur(3, 10);   tick();
    add(4, 3, 5);  #1;
    chk("lu_stall_on", 32'(mif.Stall), 32'd1);
    tick();
    chk("lu_stall_off", 32'(mif.Stall), 32'd0);
    chk("lu_count", 32'(mif.StallCount), 32'd1);
    chk_sel("lu_bubble", 2'd0, 2'd0);
    tick();
    chk_sel("lu_issue", 2'd2, 2'd0);
    drain();

    // XZR handling.
    add(31, 5, 6); tick();
    add(6, 31, 31); tick(); chk_sel("xzr_both", 2'd3, 2'd3);
    put(1'b1, 6, 31, 31, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick(); chk_sel("xzr_rm_unused", 2'd3, 2'd0);
    drain();
    ldur(31, 5);   tick();
    add(4, 31, 31); #1;
    chk("xzr_load_no_stall", 32'(mif.Stall), 32'd0);
    tick(); chk_sel("xzr_load_use", 2'd3, 2'd3);
    drain();
    add(1, 5, 6);  tick();
    put(1'b1, 8, 1, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick(); chk_sel("unused_match", 2'd0, 2'd1);
    drain();

    // Flush during a load-use stall: bubble, no count, flushed Rd not forwarded.
    ldur(3, 10);   tick();
    put(1'b1, 4, 3, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); #1;
    chk("flush_stall", 32'(mif.Stall), 32'd0);
    tick();
    chk_sel("flush_bubble", 2'd0, 2'd0);
    chk("flush_count", 32'(mif.StallCount), 32'd1);
    add(8, 4, 3);  #1;
    chk("post_flush_stall", 32'(mif.Stall), 32'd0);
    tick(); chk_sel("post_flush", 2'd0, 2'd2);
    drain();

    // 19 stall events (2^4+3 for the 4-bit instance): alternating issue/stall of LDUR X3,[X3].
    ldur(3, 3);
    repeat (38) tick();
    chk("sat_count_main", 32'(mif.StallCount), 32'd20);
    chk("sat_count_4b", 32'(sif.StallCount), 32'hF);
    drain();

    // Asynchronous reset between edges, in the middle of a stall.
    add(10, 1, 2); tick();
    ldur(3, 10);   tick();
    chk_sel("pre_reset", 2'd1, 2'd0);
    add(4, 3, 5);  #1;
    chk("pre_reset_stall", 32'(mif.Stall), 32'd1);
    Rst = 1'b0;
    #1;
    chk_sel("async_reset", 2'd0, 2'd0);
    chk("async_reset_stall", 32'(mif.Stall), 32'd0);
    chk("async_reset_count", 32'(mif.StallCount), 32'd0);
    chk("async_reset_count_4b", 32'(sif.StallCount), 32'd0);
    #2;
    Rst = 1'b1;
    tick();
    chk_sel("after_reset", 2'd0, 2'd0);
    drain();

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
